// File: rtl/br_cmp_arbiter_pkg.sv
// Shared RV32I branch types used by the branch comparator arbiter and its sub-blocks.
// Holds the operand word type, the branch funct3 encoding and the sequential PC step.
package br_cmp_arbiter_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    localparam rv32i_word PC_INC = 32'd4;

endpackage

// File: rtl/br_cmp_arbiter_if.sv
// Request/result bundle between the branch requesters, the shared comparator
// arbiter and the writeback/fetch-redirect consumer.
interface br_cmp_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4
);
    logic                               flush;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][2:0]            req_cmpop;
    logic [NUM_REQ-1:0][31:0]           req_rs1;
    logic [NUM_REQ-1:0][31:0]           req_rs2;
    logic [NUM_REQ-1:0][31:0]           req_pc;
    logic [NUM_REQ-1:0][31:0]           req_target;
    logic [NUM_REQ-1:0]                 req_pred_taken;
    logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag;
    logic                               res_valid;
    logic                               res_ready;
    logic [TAG_W-1:0]                   res_tag;
    logic                               res_taken;
    logic [31:0]                        res_next_pc;
    logic                               res_mispredict;
    logic                               res_illegal;

    modport master (
        output flush, req_valid, req_cmpop, req_rs1, req_rs2, req_pc,
               req_target, req_pred_taken, req_tag, res_ready,
        input  req_ready, res_valid, res_tag, res_taken, res_next_pc,
               res_mispredict, res_illegal
    );

    modport slave (
        input  flush, req_valid, req_cmpop, req_rs1, req_rs2, req_pc,
               req_target, req_pred_taken, req_tag, res_ready,
        output req_ready, res_valid, res_tag, res_taken, res_next_pc,
               res_mispredict, res_illegal
    );
endinterface

// File: rtl/br_cmp_arbiter_cmp.sv
// Branch comparator (cmp) plus the reusable round-robin arbiter (rr_arbiter)
// used by br_cmp_arbiter.
module cmp
    import br_cmp_arbiter_pkg::*;
(
    input  branch_funct3_t cmpop,
    input  rv32i_word      a,
    input  rv32i_word      b,
    output logic           br_en,
    output logic           illegal
);

    // Evaluate the branch condition; unused funct3 codes resolve not-taken and flag illegal.
    always_comb begin
        br_en   = 1'b0;
        illegal = 1'b0;
        case (cmpop)
            beq:     br_en = (a == b);
            bne:     br_en = (a != b);
            blt:     br_en = ($signed(a) <  $signed(b));
            bge:     br_en = ($signed(a) >= $signed(b));
            bltu:    br_en = (a <  b);
            bgeu:    br_en = (a >= b);
            default: begin
                br_en   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    // First asserted request at or after ptr, wrapping modulo N.
    always_comb begin
        int unsigned idx_v;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx_v       = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_v = 32'(ptr) + k;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_valid && req[PTR_W'(idx_v)]) begin
                grant_valid             = 1'b1;
                grant_idx               = PTR_W'(idx_v);
                grant[PTR_W'(idx_v)]    = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/br_cmp_arbiter.sv
// Shares one branch comparator among NUM_REQ requesters: round-robin grant,
// compare, and a one-entry registered result buffer with valid/ready handshake.
module br_cmp_arbiter
    import br_cmp_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    br_cmp_arbiter_if.slave   bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        branch_funct3_t   cmpop;
        rv32i_word        rs1;
        rv32i_word        rs2;
        rv32i_word        pc;
        rv32i_word        target;
        logic             pred_taken;
        logic [TAG_W-1:0] tag;
    } br_req_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        rv32i_word        next_pc;
        logic             mispredict;
        logic             illegal;
    } br_res_t;

    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   ptr_nxt_s;
    logic               res_valid_r;
    br_res_t            res_r;
    br_res_t            res_nxt_s;
    br_req_t            sel_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               grant_valid_s;
    logic               can_accept_s;
    logic               transfer_s;
    logic               taken_s;
    logic               illegal_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req         (bus.req_valid),
        .ptr         (ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // The buffer can take a new result when empty or draining, unless squashed or in reset.
    always_comb begin
        can_accept_s = !bus.flush && (!res_valid_r || bus.res_ready);
        transfer_s   = grant_valid_s && can_accept_s && !rst;
    end

    // Present the grant only when the transfer will actually complete.
    always_comb begin
        if (transfer_s) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Route the granted requester onto the shared comparator.
    always_comb begin
        sel_s.cmpop      = branch_funct3_t'(bus.req_cmpop[grant_idx_s]);
        sel_s.rs1        = bus.req_rs1[grant_idx_s];
        sel_s.rs2        = bus.req_rs2[grant_idx_s];
        sel_s.pc         = bus.req_pc[grant_idx_s];
        sel_s.target     = bus.req_target[grant_idx_s];
        sel_s.pred_taken = bus.req_pred_taken[grant_idx_s];
        sel_s.tag        = bus.req_tag[grant_idx_s];
    end

    cmp u_cmp (
        .cmpop   (sel_s.cmpop),
        .a       (sel_s.rs1),
        .b       (sel_s.rs2),
        .br_en   (taken_s),
        .illegal (illegal_s)
    );

    // Resolve next PC and mispredict; the sequential PC wraps at 2^32.
    always_comb begin
        res_nxt_s.tag        = sel_s.tag;
        res_nxt_s.taken      = taken_s;
        res_nxt_s.next_pc    = taken_s ? sel_s.target : (sel_s.pc + PC_INC);
        res_nxt_s.mispredict = taken_s ^ sel_s.pred_taken;
        res_nxt_s.illegal    = illegal_s;
    end

    // Pointer moves just past the winner so the other requesters get the next turn.
    always_comb begin
        if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + PTR_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (transfer_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Result buffer valid flag: flush beats both accept and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r <= 1'b0;
        end else if (bus.flush) begin
            res_valid_r <= 1'b0;
        end else if (transfer_s) begin
            res_valid_r <= 1'b1;
        end else if (res_valid_r && bus.res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Result payload only changes on a completed transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r <= '0;
        end else if (transfer_s) begin
            res_r <= res_nxt_s;
        end else begin
            res_r <= res_r;
        end
    end

    assign bus.res_valid      = res_valid_r;
    assign bus.res_tag        = res_r.tag;
    assign bus.res_taken      = res_r.taken;
    assign bus.res_next_pc    = res_r.next_pc;
    assign bus.res_mispredict = res_r.mispredict;
    assign bus.res_illegal    = res_r.illegal;

endmodule

// File: tb/tb_br_cmp_arbiter.sv
// Self-checking bench for br_cmp_arbiter: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the arbiter.
module tb_br_cmp_arbiter;

    localparam int N  = 2;
    localparam int TW = 4;

    logic clk;
    logic rst;

    br_cmp_arbiter_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

    br_cmp_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_valid;
    bit [TW-1:0] m_tag;
    bit          m_taken;
    bit [31:0]   m_npc;
    bit          m_mis;
    bit          m_ill;

    function automatic bit ref_taken(input bit [2:0] op, input bit [31:0] a,
                                     input bit [31:0] b, output bit ill);
        ill = 1'b0;
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: begin ill = 1'b1; return 1'b0; end
        endcase
    endfunction

    function automatic int ref_grant();
        if (rst || bus.flush || (m_valid && !bus.res_ready)) return -1;
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] v;
        int g;
        v = '0;
        g = ref_grant();
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [TW+35:0] dut_res();
        return {bus.res_valid, bus.res_tag, bus.res_taken, bus.res_next_pc,
                bus.res_mispredict, bus.res_illegal};
    endfunction

    function automatic logic [TW+35:0] ref_res();
        return {m_valid, m_tag, m_taken, m_npc, m_mis, m_ill};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = '0; m_taken = 0; m_npc = '0; m_mis = 0; m_ill = 0;
    endtask

    // Advance one clock edge and update the model; returns the model's grant.
    task automatic tick(output int g);
        bit ill;
        bit t;
        g = ref_grant();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (g >= 0) begin
            t       = ref_taken(bus.req_cmpop[g], bus.req_rs1[g], bus.req_rs2[g], ill);
            m_valid = 1'b1;
            m_tag   = bus.req_tag[g];
            m_taken = t;
            m_ill   = ill;
            m_npc   = t ? bus.req_target[g] : bus.req_pc[g] + 32'd4;
            m_mis   = t ^ bus.req_pred_taken[g];
            m_ptr   = (g + 1) % N;
        end else if (m_valid && bus.res_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit [2:0] op,
                           input bit [31:0] a, input bit [31:0] b,
                           input bit [31:0] pc, input bit [31:0] tgt,
                           input bit pred, input bit [TW-1:0] tag);
        bus.req_valid[i]      = v;
        bus.req_cmpop[i]      = op;
        bus.req_rs1[i]        = a;
        bus.req_rs2[i]        = b;
        bus.req_pc[i]         = pc;
        bus.req_target[i]     = tgt;
        bus.req_pred_taken[i] = pred;
        bus.req_tag[i]        = tag;
    endtask

    function automatic bit [31:0] pick_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0005;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_req(input int i);
        bit [31:0] pc;
        pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        set_req(i, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), pick_word(),
                pick_word(), pc, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                TW'($urandom_range(0, 15)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        n_total++;
        if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b want 00", bus.req_ready);
        else n_pass++;
        n_total++;
        if (dut_res() !== ref_res()) $display("FAIL reset_res: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        int g;
        set_req(0, 1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h180, 1'b0, 4'hA);
        bus.res_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== exp_ready()) $display("FAIL single_ready: got %b want %b", bus.req_ready, exp_ready());
        else n_pass++;
        tick(g);
        bus.req_valid[0] = 1'b0;
        n_total++;
        if (dut_res() !== ref_res()) $display("FAIL single_res: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        n_total++;
        if (bus.res_next_pc !== 32'h180 || bus.res_mispredict !== 1'b1 || bus.res_tag !== 4'hA)
            $display("FAIL single_fields: got npc=%h mis=%b tag=%h want npc=180 mis=1 tag=a",
                     bus.res_next_pc, bus.res_mispredict, bus.res_tag);
        else n_pass++;
        tick(g);
        n_total++;
        if (bus.res_valid !== m_valid) $display("FAIL single_drain: got %b want %b", bus.res_valid, m_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int g;
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, 3'b001, 32'd3, 32'd4, 32'h300, 32'h340, 1'b1, 4'h3);
        set_req(1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h240, 1'b0, 4'h5);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) bus.req_cmpop[1] = 3'b110;
            #1;
            n_total++;
            if (bus.req_ready !== exp_ready()) $display("FAIL b2b_ready: got %b want %b", bus.req_ready, exp_ready());
            else n_pass++;
            tick(g);
            n_total++;
            if (dut_res() !== ref_res()) $display("FAIL b2b_res: got %h want %h", dut_res(), ref_res());
            else n_pass++;
            if (g == 1) begin
                n_total++;
                if (bus.res_taken !== (c < 4)) $display("FAIL b2b_req1_taken: got %b want %b", bus.res_taken, (c < 4));
                else n_pass++;
            end
        end
        bus.req_valid = '0;
        tick(g);
    endtask

    task automatic test_backpressure();
        int g;
        logic [TW+35:0] snap;
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, 3'b101, 32'd9, 32'd2, 32'h400, 32'h480, 1'b1, 4'h7);
        set_req(1, 1'b1, 3'b111, 32'd1, 32'd9, 32'h500, 32'h580, 1'b1, 4'h8);
        #1;
        tick(g);
        bus.req_valid[g] = 1'b0;
        snap = dut_res();
        n_total++;
        if (bus.res_valid !== 1'b1) $display("FAIL bp_load: got %b want 1", bus.res_valid);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if (bus.req_ready !== '0) $display("FAIL bp_stall_ready: got %b want 00", bus.req_ready);
            else n_pass++;
            tick(g);
            n_total++;
            if (dut_res() !== snap || dut_res() !== ref_res())
                $display("FAIL bp_hold: got %h want %h", dut_res(), ref_res());
            else n_pass++;
        end
        bus.res_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== exp_ready() || bus.req_ready === '0)
            $display("FAIL bp_release_ready: got %b want %b", bus.req_ready, exp_ready());
        else n_pass++;
        tick(g);
        n_total++;
        if (dut_res() !== ref_res()) $display("FAIL bp_release_res: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_valid = '0;
        tick(g);
    endtask

    task automatic test_flush();
        int g;
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, 3'b000, 32'd1, 32'd1, 32'h600, 32'h680, 1'b1, 4'h1);
        #1;
        tick(g);
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, 3'b001, 32'd1, 32'd2, 32'h700, 32'h780, 1'b0, 4'h2);
        bus.flush = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== '0) $display("FAIL flush_ready: got %b want 00", bus.req_ready);
        else n_pass++;
        tick(g);
        n_total++;
        if (bus.res_valid !== 1'b0 || dut_res() !== ref_res())
            $display("FAIL flush_res: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.flush = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== exp_ready()) $display("FAIL flush_ptr_hold: got %b want %b", bus.req_ready, exp_ready());
        else n_pass++;
        tick(g);
        n_total++;
        if (dut_res() !== ref_res()) $display("FAIL flush_after_res: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_valid = '0;
        tick(g);
    endtask

    task automatic test_edge();
        int g;
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, 3'b111, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 1'b1, 4'h3);
        #1;
        tick(g);
        n_total++;
        if (dut_res() !== ref_res() || bus.res_next_pc !== 32'h0)
            $display("FAIL edge_wrap: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_cmpop[0] = 3'b010;
        bus.req_rs2[0] = 32'd1;
        #1;
        tick(g);
        n_total++;
        if (dut_res() !== ref_res() || bus.res_illegal !== 1'b1 || bus.res_taken !== 1'b0)
            $display("FAIL edge_illegal: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_valid = '0;
        tick(g);
    endtask

    task automatic test_async_reset();
        int g;
        bus.res_ready = 1'b0;
        set_req(1, 1'b1, 3'b000, 32'd2, 32'd2, 32'h800, 32'h880, 1'b0, 4'h9);
        #1;
        tick(g);
        bus.req_valid = '0;
        n_total++;
        if (bus.res_valid !== 1'b1) $display("FAIL arst_pre: got %b want 1", bus.res_valid);
        else n_pass++;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (dut_res() !== ref_res()) $display("FAIL arst_immediate: got %h want %h", dut_res(), ref_res());
        else n_pass++;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        tick(g);
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.res_valid !== 1'b0) $display("FAIL arst_after: got %b want 0", bus.res_valid);
        else n_pass++;
        n_total++;
        if (bus.req_ready !== exp_ready()) $display("FAIL arst_ptr: got %b want %b", bus.req_ready, exp_ready());
        else n_pass++;
        bus.req_valid = '0;
        tick(g);
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < N; i++) rand_req(i);
        for (int c = 0; c < 400; c++) begin
            bus.res_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            #1;
            n_total++;
            if (bus.req_ready !== exp_ready()) $display("FAIL rand_ready: cycle %0d got %b want %b", c, bus.req_ready, exp_ready());
            else n_pass++;
            tick(g);
            n_total++;
            if (dut_res() !== ref_res()) $display("FAIL rand_res: cycle %0d got %h want %h", c, dut_res(), ref_res());
            else n_pass++;
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] || g == i) rand_req(i);
        end
        bus.req_valid = '0;
        bus.flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_edge();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d of %0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
